// File: rtl/ddr3_read_arbiter.sv
// ---------------------------------------------------------------------------
// ddr3_read_arbiter
//
// Shares the single DDR3 read port between the network's fetch requesters
// (weight, bias and operand loaders, resizer/pool readers). Each requester
// posts a burst (base byte address, word count). Bursts are granted one at a
// time in round-robin order; the granted burst issues one word read per
// cycle, and returning data is steered back to its owner with a one-hot
// valid.
//
// Ports:
//   clock         in   single clock, all state on its rising edge
//   reset         in   synchronous active-high reset
//   req_valid     in   [NUM_REQ]            burst request, held until accepted
//   req_addr      in   [NUM_REQ*ADDR_WIDTH] burst base byte address per requester
//   req_len       in   [NUM_REQ*LEN_WIDTH]  burst length in words per requester
//   req_ready     out  [NUM_REQ]            one-hot, one-cycle accept pulse
//   DDR3_Address  out  [ADDR_WIDTH]         read address (0 when not reading)
//   DDR3_Read     out                       read strobe, one word per cycle
//   DDR3_Input    in   [DATA_WIDTH]         read data, READ_LATENCY after strobe
//   rd_data       out  [DATA_WIDTH]         pass-through of DDR3_Input
//   rd_valid      out  [NUM_REQ]            one-hot owner of rd_data
//   burst_done    out  [NUM_REQ]            one-hot pulse on owner's last beat
//   busy          out                       high whenever not idle
// ---------------------------------------------------------------------------
module ddr3_read_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int LEN_WIDTH    = 16,
    parameter int READ_LATENCY = 2,
    parameter int WORD_BYTES   = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [ADDR_WIDTH-1:0]           DDR3_Address,
    output logic                            DDR3_Read,
    input  logic [DATA_WIDTH-1:0]           DDR3_Input,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [NUM_REQ-1:0]              rd_valid,
    output logic [NUM_REQ-1:0]              burst_done,
    output logic                            busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ZERO  = 2'd3
    } state_t;

    // (ptr + offset) mod NUM_REQ, with offset < NUM_REQ and ptr < NUM_REQ
    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] ptr,
                                                  input int offset);
        int sum;
        sum = int'(ptr) + offset;
        return (sum >= NUM_REQ) ? IDX_W'(sum - NUM_REQ) : IDX_W'(sum);
    endfunction

    // Index to one-hot requester vector
    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx == IDX_W'(i)) begin
                vec[i] = 1'b1;
            end else begin
                vec[i] = 1'b0;
            end
        end
        return vec;
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    logic [IDX_W-1:0]        rr_ptr_r;
    logic [NUM_REQ-1:0]      owner_r;
    logic [ADDR_WIDTH-1:0]   base_r;
    logic [LEN_WIDTH-1:0]    len_r;
    logic [LEN_WIDTH-1:0]    count_r;

    logic                    win_found_s;
    logic [IDX_W-1:0]        win_idx_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [LEN_WIDTH-1:0]    sel_len_s;
    logic                    accept_s;
    logic                    issue_s;
    logic                    last_beat_s;
    logic                    inflight_s;
    logic [ADDR_WIDTH-1:0]   addr_calc_s;

    // Return pipeline: one entry per issued read, READ_LATENCY deep
    logic [READ_LATENCY-1:0] pipe_valid_r;
    logic [NUM_REQ-1:0]      pipe_owner_r [READ_LATENCY];

    // Round-robin winner search, starting at rr_ptr and wrapping
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found_s && req_valid[rr_index(rr_ptr_r, k)]) begin
                win_found_s = 1'b1;
                win_idx_s   = rr_index(rr_ptr_r, k);
            end else begin
                win_found_s = win_found_s;
                win_idx_s   = win_idx_s;
            end
        end
    end

    // Pick the winner's address and length slices
    always_comb begin
        sel_addr_s = '0;
        sel_len_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx_s == IDX_W'(i)) begin
                sel_addr_s = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len_s  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
            end else begin
                sel_addr_s = sel_addr_s;
                sel_len_s  = sel_len_s;
            end
        end
    end

    // Accept only from IDLE; an accept during reset would be discarded, so
    // it is suppressed to keep req_ready truthful
    always_comb begin
        accept_s = (state_r == ST_IDLE) && win_found_s && !reset;
        issue_s  = (state_r == ST_BURST);
    end

    // Any read still in flight ahead of the pipeline output stage
    always_comb begin
        inflight_s = 1'b0;
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
            inflight_s = inflight_s | pipe_valid_r[i];
        end
    end

    // In DRAIN no new reads enter, so the output beat is the last one once
    // every earlier stage is empty
    always_comb begin
        last_beat_s = pipe_valid_r[READ_LATENCY-1] && !inflight_s;
    end

    // Word address of the current beat; wraps silently at ADDR_WIDTH
    always_comb begin
        addr_calc_s = base_r + (ADDR_WIDTH'(count_r) * ADDR_WIDTH'(WORD_BYTES));
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (sel_len_s != '0) begin
                        state_next_s = ST_BURST;
                    end else begin
                        state_next_s = ST_ZERO;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (count_r == (len_r - LEN_WIDTH'(1))) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_BURST;
                end
            end
            ST_DRAIN: begin
                if (last_beat_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_ZERO: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        req_ready    = '0;
        DDR3_Read    = 1'b0;
        DDR3_Address = '0;
        burst_done   = '0;
        busy         = 1'b1;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
                if (accept_s) begin
                    req_ready = to_onehot(win_idx_s);
                end else begin
                    req_ready = '0;
                end
            end
            ST_BURST: begin
                DDR3_Read    = 1'b1;
                DDR3_Address = addr_calc_s;
            end
            ST_DRAIN: begin
                if (last_beat_s) begin
                    burst_done = owner_r;
                end else begin
                    burst_done = '0;
                end
            end
            ST_ZERO: begin
                burst_done = owner_r;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Burst bookkeeping: owner, base, length, beat counter and rotation pointer
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_r <= '0;
            owner_r  <= '0;
            base_r   <= '0;
            len_r    <= '0;
            count_r  <= '0;
        end else if (accept_s) begin
            rr_ptr_r <= rr_index(win_idx_s, 1);
            owner_r  <= to_onehot(win_idx_s);
            base_r   <= sel_addr_s;
            len_r    <= sel_len_s;
            count_r  <= '0;
        end else if (issue_s) begin
            count_r  <= count_r + LEN_WIDTH'(1);
        end else begin
            count_r  <= count_r;
        end
    end

    // Return pipeline shift; reset flushes it so stale returns are dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_valid_r <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_owner_r[i] <= '0;
            end
        end else begin
            pipe_valid_r[0] <= issue_s;
            pipe_owner_r[0] <= owner_r;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
                pipe_owner_r[i] <= pipe_owner_r[i-1];
            end
        end
    end

    // Data steering
    always_comb begin
        rd_data = DDR3_Input;
        if (pipe_valid_r[READ_LATENCY-1]) begin
            rd_valid = pipe_owner_r[READ_LATENCY-1];
        end else begin
            rd_valid = '0;
        end
    end

endmodule

// File: tb/tb_ddr3_read_arbiter.sv
module tb_ddr3_read_arbiter;

    localparam int RL = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [95:0] req_addr;
    logic [47:0] req_len;
    logic [2:0]  req_ready;
    logic [31:0] DDR3_Address;
    logic        DDR3_Read;
    logic [31:0] DDR3_Input;
    logic [31:0] rd_data;
    logic [2:0]  rd_valid;
    logic [2:0]  burst_done;
    logic        busy;

    int   tests_run = 0;
    int   tests_failed = 0;
    logic mon_en = 1'b0;
    logic [31:0] mem_q1 = 32'd0;
    logic [31:0] mem_q2 = 32'd0;

    ddr3_read_arbiter #(
        .NUM_REQ(3), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .LEN_WIDTH(16), .READ_LATENCY(RL), .WORD_BYTES(4)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
        .req_ready(req_ready),
        .DDR3_Address(DDR3_Address), .DDR3_Read(DDR3_Read), .DDR3_Input(DDR3_Input),
        .rd_data(rd_data), .rd_valid(rd_valid), .burst_done(burst_done), .busy(busy)
    );

    always #5 clock = ~clock;

    // Memory contents as a function of the word address
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [2:0] oh(input int i);
        return 3'b001 << i;
    endfunction

    // DDR3 responder with a two-cycle read latency
    always @(posedge clock) begin
        mem_q1 <= DDR3_Read ? mem_f(DDR3_Address) : 32'd0;
        mem_q2 <= mem_q1;
    end
    assign DDR3_Input = mem_q2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [15:0] l);
        req_valid[i]        = 1'b1;
        req_addr[i*32 +: 32] = a;
        req_len[i*16 +: 16]  = l;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_read"}, DDR3_Read, 0);
        chk({tag, "_addr"}, DDR3_Address, 0);
        chk({tag, "_rdv"}, rd_valid, 0);
        chk({tag, "_done"}, burst_done, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        mid();
        all_zero("rst");
        cyc();
        reset = 1'b0;
    endtask

    // Called at the start of an idle cycle with the request already driven.
    // Checks accept, the whole read/return timeline, and returns at the start
    // of the first idle cycle after burst_done. The owner's request is
    // dropped and its address/length scrambled right after acceptance;
    // optionally another requester is raised while the burst runs.
    task automatic burst(input int own, input logic [31:0] base, input int len,
                         input int late, input logic [31:0] late_addr,
                         input logic [15:0] late_len);
        logic [31:0] exp_a;
        mid();
        chk("accept", req_ready, oh(own));
        chk("accept_busy", busy, 0);
        chk("accept_rdv", rd_valid, 0);
        chk("accept_read", DDR3_Read, 0);
        cyc();
        req_valid[own]         = 1'b0;
        req_addr[own*32 +: 32] = 32'hBAD0_0000;
        req_len[own*16 +: 16]  = 16'd5;
        if (late >= 0) begin
            set_req(late, late_addr, late_len);
        end
        if (len == 0) begin
            mid();
            chk("zero_read", DDR3_Read, 0);
            chk("zero_rdv", rd_valid, 0);
            chk("zero_done", burst_done, oh(own));
            chk("zero_busy", busy, 1);
            cyc();
        end else begin
            for (int k = 1; k <= len + RL; k++) begin
                mid();
                chk("busy", busy, 1);
                chk("ready_hold", req_ready, 0);
                chk("rd_strobe", DDR3_Read, (k <= len) ? 1 : 0);
                if (k <= len) begin
                    exp_a = base + 32'(4 * (k - 1));
                    chk("rd_addr", DDR3_Address, exp_a);
                end
                if (k > RL) begin
                    exp_a = base + 32'(4 * (k - 1 - RL));
                    chk("rd_valid", rd_valid, oh(own));
                    chk("rd_data", rd_data, mem_f(exp_a));
                end else begin
                    chk("rd_valid_early", rd_valid, 0);
                end
                chk("burst_done", burst_done, (k == len + RL) ? oh(own) : 0);
                cyc();
            end
        end
    endtask

    // Continuous properties: one owner at most, address idles at zero
    always @(negedge clock) begin
        if (mon_en) begin
            chk("rdv_onehot", {63'd0, $onehot0(rd_valid)}, 64'd1);
            if (!DDR3_Read) begin
                chk("idle_addr", DDR3_Address, 0);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 3'b000;
        req_addr  = 96'd0;
        req_len   = 48'd0;
        do_reset();
        mon_en = 1'b1;

        // Single burst: req 0, 0x100, 4 words
        set_req(0, 32'h0000_0100, 16'd4);
        burst(0, 32'h0000_0100, 4, -1, 32'd0, 16'd0);
        mid();
        chk("single_busy_low", busy, 0);

        // Round robin from a fresh reset: order 0,1,2 then 0,1
        cyc();
        do_reset();
        set_req(0, 32'h0000_1000, 16'd2);
        set_req(1, 32'h0000_2000, 16'd2);
        set_req(2, 32'h0000_3000, 16'd2);
        burst(0, 32'h0000_1000, 2, -1, 32'd0, 16'd0);
        burst(1, 32'h0000_2000, 2, -1, 32'd0, 16'd0);
        burst(2, 32'h0000_3000, 2, -1, 32'd0, 16'd0);
        set_req(0, 32'h0000_1100, 16'd2);
        set_req(1, 32'h0000_2100, 16'd2);
        burst(0, 32'h0000_1100, 2, -1, 32'd0, 16'd0);
        burst(1, 32'h0000_2100, 2, -1, 32'd0, 16'd0);

        // Zero-length burst on req 1
        set_req(1, 32'h0000_7000, 16'd0);
        burst(1, 32'h0000_7000, 0, -1, 32'd0, 16'd0);

        // Address wrap
        set_req(0, 32'hFFFF_FFF8, 16'd4);
        burst(0, 32'hFFFF_FFF8, 4, -1, 32'd0, 16'd0);

        // Back-pressure: req 1 raised while req 0 runs, granted on first idle
        set_req(0, 32'h0000_0200, 16'd3);
        burst(0, 32'h0000_0200, 3, 1, 32'h0000_0300, 16'd2);
        burst(1, 32'h0000_0300, 2, -1, 32'd0, 16'd0);

        // Reset during the third read of an 8-word burst
        set_req(1, 32'h0000_4000, 16'd8);
        mid();
        chk("mr_accept", req_ready, 3'b010);
        cyc();
        req_valid[1] = 1'b0;
        mid();
        chk("mr_addr0", DDR3_Address, 32'h0000_4000);
        cyc();
        mid();
        chk("mr_addr1", DDR3_Address, 32'h0000_4004);
        cyc();
        reset = 1'b1;
        mid();
        chk("mr_read2", DDR3_Read, 1);
        chk("mr_addr2", DDR3_Address, 32'h0000_4008);
        chk("mr_rdv", rd_valid, 3'b010);
        chk("mr_data", rd_data, mem_f(32'h0000_4000));
        cyc();
        reset = 1'b0;
        mid();
        all_zero("mr_after");
        cyc();
        set_req(2, 32'h0000_5000, 16'd1);
        burst(2, 32'h0000_5000, 1, -1, 32'd0, 16'd0);
        mid();
        chk("end_busy", busy, 0);
        chk("end_done", burst_done, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
